tap_delay_line: RTL and testbench

- Parametrised, valid-gated tapped delay line for the FIR datapath.
- Shifts accepted input samples through TAPS register stages and exposes every stage in parallel to the multiply-accumulate array.
- Tracks how many stages hold real data; the MAC suppresses output until the line is primed.
- Supports a synchronous flush between sample streams.

---
 rtl/fir_pkg.sv | 13 +
 rtl/dly_stage_en.sv | 25 ++
 rtl/tap_delay_line.sv | 72 +++++++
 tb/tb_tap_delay_line.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR datapath blocks.
package fir_pkg;

    localparam int DEF_N    = 16;
    localparam int DEF_TAPS = 8;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        PRIMED
    } fill_state_t;

endpackage

// File: rtl/dly_stage_en.sv
// Single N-bit delay register with async active-low reset, sync clear and enable.
module dly_stage_en
    import fir_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/tap_delay_line.sv
// Valid-gated tapped delay line exposing every stage, with fill tracking for the MAC.
module tap_delay_line
    import fir_pkg::*;
#(
    parameter  int N     = DEF_N,
    parameter  int TAPS  = DEF_TAPS,
    localparam int CNT_W = $clog2(TAPS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [N-1:0]      data_in,
    output logic [TAPS*N-1:0] taps_out,
    output logic              out_valid,
    output logic              primed,
    output logic [CNT_W-1:0]  fill_count
);

    logic              accept;
    logic [N-1:0]      stage [TAPS];
    fill_state_t       state, state_next;
    logic [CNT_W-1:0]  count_next;

    // Flush dominates a coincident sample, so that sample is dropped.
    assign accept = in_valid & ~flush;

    for (genvar k = 0; k < TAPS; k++) begin : g_stage
        dly_stage_en #(.N(N)) u_stage (
            .clk   (clk),
            .reset (reset),
            .clr   (flush),
            .en    (accept),
            .d     ((k == 0) ? data_in : stage[(k == 0) ? 0 : k - 1]),
            .q     (stage[k])
        );
        assign taps_out[k*N +: N] = stage[k];
    end

    always_comb begin
        state_next = state;
        count_next = fill_count;
        if (flush) begin
            state_next = EMPTY;
            count_next = '0;
        end else if (in_valid) begin
            if (fill_count != CNT_W'(TAPS)) begin
                count_next = fill_count + 1'b1;
            end
            case (state)
                EMPTY:   state_next = FILLING;
                FILLING: if (fill_count == CNT_W'(TAPS - 1)) state_next = PRIMED;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= EMPTY;
            fill_count <= '0;
            out_valid  <= 1'b0;
        end else begin
            state      <= state_next;
            fill_count <= count_next;
            out_valid  <= accept;
        end
    end

    assign primed = (state == PRIMED);

endmodule

// File: tb/tb_tap_delay_line.sv
// Directed self-checking bench for tap_delay_line (TAPS=8 main instance, TAPS=2 corner instance).
module tb_tap_delay_line;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [15:0]   data_in;
    logic [127:0]  taps_out;
    logic          out_valid;
    logic          primed;
    logic [3:0]    fill_count;
    logic [31:0]   taps_out2;
    logic          out_valid2;
    logic          primed2;
    logic [1:0]    fill_count2;

    int checks = 0;
    int errors = 0;

    tap_delay_line #(.N(16), .TAPS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .taps_out   (taps_out),
        .out_valid  (out_valid),
        .primed     (primed),
        .fill_count (fill_count)
    );

    tap_delay_line #(.N(16), .TAPS(2)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .taps_out   (taps_out2),
        .out_valid  (out_valid2),
        .primed     (primed2),
        .fill_count (fill_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] stg(input logic [127:0] t, input int k);
        return t[k*16 +: 16];
    endfunction

    // Drives one cycle of inputs, then returns 1 time unit after the edge.
    task automatic cycle(input logic v, input logic [15:0] d, input logic f);
        in_valid = v;
        data_in  = d;
        flush    = f;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b1;
        data_in  = 16'hABCD;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (taps_out !== '0 || out_valid !== 1'b0 || primed !== 1'b0 || fill_count !== 4'd0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: taps=%h ov=%b pr=%b fc=%0d, want all 0", i, taps_out, out_valid, primed, fill_count);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_fill();
        apply_reset();
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 16'(i), 1'b0);
            checks++;
            if (out_valid !== 1'b1 || fill_count !== 4'(i)) begin
                errors++;
                $display("FAIL fill_step[%0d]: ov=%b fc=%0d, want ov=1 fc=%0d", i, out_valid, fill_count, i);
            end
            checks++;
            if (primed !== (i == 8)) begin
                errors++;
                $display("FAIL fill_primed[%0d]: primed=%b want %b", i, primed, (i == 8));
            end
            if (i <= 2) begin
                checks++;
                if (primed2 !== (i == 2) || fill_count2 !== 2'(i)) begin
                    errors++;
                    $display("FAIL taps2_primed[%0d]: primed=%b fc=%0d want primed=%b fc=%0d", i, primed2, fill_count2, (i == 2), i);
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (stg(taps_out, k) !== 16'(8 - k)) begin
                errors++;
                $display("FAIL fill_stage%0d: got %h want %h", k, stg(taps_out, k), 16'(8 - k));
            end
        end
        checks++;
        if (stg({96'd0, taps_out2}, 0) !== 16'd8 || stg({96'd0, taps_out2}, 1) !== 16'd7) begin
            errors++;
            $display("FAIL taps2_stages: got %h want 00070008", taps_out2);
        end
        cycle(1'b0, 16'h0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || primed !== 1'b1 || fill_count !== 4'd8) begin
            errors++;
            $display("FAIL fill_idle: ov=%b pr=%b fc=%0d want ov=0 pr=1 fc=8", out_valid, primed, fill_count);
        end
    endtask

    task automatic test_gaps();
        logic        vpat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] dpat [6] = '{16'd1, 16'hDEAD, 16'hBEEF, 16'd2, 16'hCAFE, 16'd3};
        int pulses = 0;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(vpat[i], dpat[i], 1'b0);
            if (out_valid === 1'b1) pulses++;
        end
        cycle(1'b0, 16'hFFFF, 1'b0);
        if (out_valid === 1'b1) pulses++;
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL gaps_pulses: got %0d want 3", pulses);
        end
        checks++;
        if (stg(taps_out, 0) !== 16'd3 || stg(taps_out, 1) !== 16'd2 || stg(taps_out, 2) !== 16'd1 || taps_out[127:48] !== '0) begin
            errors++;
            $display("FAIL gaps_stages: got %h want ...0001_0002_0003", taps_out);
        end
        checks++;
        if (fill_count !== 4'd3 || primed !== 1'b0) begin
            errors++;
            $display("FAIL gaps_fill: fc=%0d pr=%b want fc=3 pr=0", fill_count, primed);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 1; i <= 10; i++) cycle(1'b1, 16'(i), 1'b0);
        checks++;
        if (stg(taps_out, 0) !== 16'h000A || stg(taps_out, 7) !== 16'h0003) begin
            errors++;
            $display("FAIL sat_stages: s0=%h s7=%h want s0=000a s7=0003", stg(taps_out, 0), stg(taps_out, 7));
        end
        checks++;
        if (fill_count !== 4'd8 || primed !== 1'b1) begin
            errors++;
            $display("FAIL sat_fill: fc=%0d pr=%b want fc=8 pr=1", fill_count, primed);
        end
    endtask

    task automatic test_flush();
        int found = 0;
        cycle(1'b1, 16'h5555, 1'b1);
        checks++;
        if (taps_out !== '0 || fill_count !== 4'd0 || primed !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: taps=%h fc=%0d pr=%b ov=%b want all 0", taps_out, fill_count, primed, out_valid);
        end
        for (int k = 0; k < 8; k++) if (stg(taps_out, k) === 16'h5555) found++;
        checks++;
        if (found != 0) begin
            errors++;
            $display("FAIL flush_dropped: 5555 found in %0d stages, want 0", found);
        end
        cycle(1'b1, 16'h1234, 1'b0);
        checks++;
        if (stg(taps_out, 0) !== 16'h1234 || fill_count !== 4'd1 || out_valid !== 1'b1 || primed !== 1'b0) begin
            errors++;
            $display("FAIL flush_refill: s0=%h fc=%0d ov=%b pr=%b want s0=1234 fc=1 ov=1 pr=0", stg(taps_out, 0), fill_count, out_valid, primed);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 1; i <= 5; i++) cycle(1'b1, 16'(16'h0100 + i), 1'b0);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (taps_out !== '0 || out_valid !== 1'b0 || primed !== 1'b0 || fill_count !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: taps=%h ov=%b pr=%b fc=%0d want all 0", taps_out, out_valid, primed, fill_count);
        end
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, 16'hFFFF, 1'b0);
        checks++;
        if (stg(taps_out, 0) !== 16'hFFFF || taps_out[127:16] !== '0 || fill_count !== 4'd1) begin
            errors++;
            $display("FAIL async_refill: taps=%h fc=%0d want s0=ffff others 0 fc=1", taps_out, fill_count);
        end
    endtask

    initial begin
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;
        test_reset();
        test_fill();
        test_gaps();
        test_saturation();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
